// File: rtl/gb_interrupt_pkg.sv
`default_nettype none
// ============================================================
// gb_interrupt_pkg: shared types and constants for the SM83
// interrupt controller.  Rev 1.0
// ============================================================
package gb_interrupt_pkg;

  typedef enum logic [1:0] {
    IME_OFF   = 2'd0,
    IME_ARMED = 2'd1,
    IME_ON    = 2'd2
  } ime_state_t;

  typedef enum logic [0:0] {
    DSP_IDLE     = 1'b0,
    DSP_DISPATCH = 1'b1
  } dispatch_state_t;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  localparam int MAX_IRQ = 8;

  localparam logic [15:0] DEF_ADDR_IF     = 16'hFF0F;
  localparam logic [15:0] DEF_ADDR_IE     = 16'hFFFF;
  localparam logic [15:0] DEF_VECTOR_BASE = 16'h0040;

endpackage
`default_nettype wire

// File: rtl/gb_irq_priority_enc.sv
`default_nettype none
// ============================================================
// gb_irq_priority_enc: lowest-set-bit priority encoder.
// Rev 1.0
// ============================================================
module gb_irq_priority_enc #(
  parameter int NUM_IRQ = 5
) (
  input  logic [NUM_IRQ-1:0] req_i,
  output logic               valid_o,
  output logic [2:0]         idx_o
);

  // Scanning downward lets the lowest index win.
  always_comb begin
    valid_o = |req_i;
    idx_o   = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = 3'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/gb_interrupt_ctrl.sv
`default_nettype none
// ============================================================
// gb_interrupt_ctrl: IF/IE registers, IME state and interrupt
// dispatch arbitration for the SM83 core.  Rev 1.0
// ============================================================
module gb_interrupt_ctrl
  import gb_interrupt_pkg::*;
#(
  parameter int          NUM_IRQ       = 5,
  parameter logic [7:0]  REQ_EDGE      = 8'h00,
  parameter logic [15:0] ADDR_IF       = DEF_ADDR_IF,
  parameter logic [15:0] ADDR_IE       = DEF_ADDR_IE,
  parameter logic [15:0] VECTOR_BASE   = DEF_VECTOR_BASE,
  parameter int          VECTOR_STRIDE = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_IRQ-1:0] irq_req_i,
  input  logic [15:0]        bus_addr_i,
  input  logic [7:0]         bus_wdata_i,
  input  logic               bus_write_en_i,
  input  logic               bus_read_en_i,
  output logic [7:0]         bus_rdata_o,
  input  logic               instr_boundary_i,
  input  logic               ime_set_delayed_i,
  input  logic               ime_set_now_i,
  input  logic               ime_clr_i,
  output logic               ime_o,
  output logic               int_pending_o,
  output logic               wake_o,
  input  logic               dispatch_start_i,
  input  logic               dispatch_ack_i,
  output logic               dispatch_active_o,
  output logic               dispatch_done_o,
  output logic [15:0]        dispatch_vector_o
);

  localparam logic [7:0]         IRQ_MASK  = 8'((16'd1 << NUM_IRQ) - 16'd1);
  localparam logic [NUM_IRQ-1:0] EDGE_MASK = REQ_EDGE[NUM_IRQ-1:0];

  logic [7:0]         if_q, if_d;
  logic [7:0]         ie_q, ie_d;
  logic [NUM_IRQ-1:0] req_prev_q;
  ime_state_t         ime_q, ime_d;
  dispatch_state_t    dsp_q, dsp_d;
  logic [15:0]        vec_q, vec_d;
  logic               done_q, done_d;

  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] req_set;
  logic               pend_valid;
  logic [2:0]         pend_idx;
  logic               wr_if, wr_ie;
  logic               dsp_enter, dsp_resolve;

  assign pend        = if_q[NUM_IRQ-1:0] & ie_q[NUM_IRQ-1:0];
  assign req_set     = irq_req_i & ~(EDGE_MASK & req_prev_q);
  assign wr_if       = bus_write_en_i && (bus_addr_i == ADDR_IF);
  assign wr_ie       = bus_write_en_i && (bus_addr_i == ADDR_IE);
  assign dsp_enter   = (dsp_q == DSP_IDLE) && dispatch_start_i && (ime_q == IME_ON);
  assign dsp_resolve = (dsp_q == DSP_DISPATCH) && dispatch_ack_i;

  gb_irq_priority_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio (
    .req_i   (pend),
    .valid_o (pend_valid),
    .idx_o   (pend_idx)
  );

  // Write, then ack clear, then new requests: a fresh request always survives.
  always_comb begin
    if_d = if_q;
    if (wr_if) if_d = bus_wdata_i;
    if (dsp_resolve && pend_valid) if_d[pend_idx] = 1'b0;
    if_d = if_d | 8'(req_set) | ~IRQ_MASK;
    ie_d = wr_ie ? bus_wdata_i : ie_q;
  end

  always_comb begin
    ime_d = ime_q;
    if (ime_clr_i) begin
      ime_d = IME_OFF;
    end else if (dsp_enter) begin
      ime_d = IME_OFF;
    end else if (ime_set_now_i) begin
      ime_d = IME_ON;
    end else begin
      case (ime_q)
        IME_OFF:   if (ime_set_delayed_i) ime_d = IME_ARMED;
        IME_ARMED: if (instr_boundary_i) ime_d = IME_ON;
        default:   ime_d = ime_q;
      endcase
    end
  end

  // Cancelled dispatch (nothing pending at resolve) jumps to 0x0000.
  always_comb begin
    dsp_d  = dsp_q;
    vec_d  = vec_q;
    done_d = 1'b0;
    case (dsp_q)
      DSP_IDLE: begin
        if (dsp_enter) dsp_d = DSP_DISPATCH;
      end
      DSP_DISPATCH: begin
        if (dispatch_ack_i) begin
          dsp_d  = DSP_IDLE;
          done_d = 1'b1;
          vec_d  = pend_valid ? (VECTOR_BASE + 16'(pend_idx) * 16'(VECTOR_STRIDE))
                              : 16'h0000;
        end
      end
      default: dsp_d = DSP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      if_q       <= ~IRQ_MASK;
      ie_q       <= 8'h00;
      req_prev_q <= '0;
      ime_q      <= IME_OFF;
      dsp_q      <= DSP_IDLE;
      vec_q      <= 16'h0000;
      done_q     <= 1'b0;
    end else begin
      if_q       <= if_d;
      ie_q       <= ie_d;
      req_prev_q <= irq_req_i;
      ime_q      <= ime_d;
      dsp_q      <= dsp_d;
      vec_q      <= vec_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    bus_rdata_o = 8'h00;
    if (bus_read_en_i) begin
      if (bus_addr_i == ADDR_IF)      bus_rdata_o = if_q;
      else if (bus_addr_i == ADDR_IE) bus_rdata_o = ie_q;
    end
  end

  assign ime_o             = (ime_q == IME_ON);
  assign wake_o            = |pend;
  assign int_pending_o     = ime_o & wake_o;
  assign dispatch_active_o = (dsp_q == DSP_DISPATCH);
  assign dispatch_done_o   = done_q;
  assign dispatch_vector_o = vec_q;

endmodule
`default_nettype wire
